// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: field widths, the special
// exponent value, the normalizer state encoding and loss-bit positions.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } norm_state_e;

    localparam int LOSS_STICKY = 1;
    localparam int LOSS_DIR    = 0;

endpackage

// File: rtl/normalize_seq.sv
// Iterative post-add normalizer: one mantissa shift per cycle until the hidden
// bit lands at mantis[MANT_W-1] or the exponent hits the denormal floor.
module normalize_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic              operator_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W:0]   mantis_in,
    input  logic [1:0]        loss_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign,
    output logic              operator,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mantis,
    output logic [1:0]        loss
);

    norm_state_e      state, state_nxt;
    logic [MANT_W:0]  m, m_nxt;
    logic [EXP_W-1:0] e, e_nxt;
    logic [1:0]       loss_r, loss_nxt;
    logic             sign_r, sign_nxt;
    logic             op_r, op_nxt;

    // NOTE: every variable gets its hold value first so no path through the
    // case/if chain leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        e_nxt     = e;
        loss_nxt  = loss_r;
        sign_nxt  = sign_r;
        op_nxt    = op_r;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    m_nxt     = mantis_in;
                    e_nxt     = exp_in;
                    loss_nxt  = loss_in;
                    sign_nxt  = sign_in;
                    op_nxt    = operator_in;
                    state_nxt = NORM;
                end
            end

            NORM: begin
                state_nxt = DONE;
                if (e == EXP_MAX) begin
                    // inf/NaN travels through untouched
                end else if (m == '0) begin
                    e_nxt = '0;
                end else if (m[MANT_W]) begin
                    m_nxt                 = m >> 1;
                    loss_nxt[LOSS_STICKY] = loss_r[LOSS_STICKY] | m[0];
                    loss_nxt[LOSS_DIR]    = loss_r[LOSS_DIR] | m[0];
                    e_nxt                 = e + 1'b1;
                    if (e == EXP_MAX - 1'b1) begin
                        m_nxt = '0;
                    end
                end else if (m[MANT_W-1]) begin
                    // hidden bit already in place
                end else if (e <= EXP_W'(1)) begin
                    // Denormal floor: one extra shift lines the fraction up
                    // with the round stage's exp==0 interpretation.
                    m_nxt = m << 1;
                    e_nxt = '0;
                end else begin
                    m_nxt     = m << 1;
                    e_nxt     = e - 1'b1;
                    state_nxt = NORM;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            m      <= '0;
            e      <= '0;
            loss_r <= '0;
            sign_r <= 1'b0;
            op_r   <= 1'b0;
        end else begin
            m      <= m_nxt;
            e      <= e_nxt;
            loss_r <= loss_nxt;
            sign_r <= sign_nxt;
            op_r   <= op_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sign      = sign_r;
    assign operator  = op_r;
    assign exp       = e;
    assign mantis    = m[MANT_W-1:0];
    assign loss      = loss_r;

endmodule

// File: tb/tb_normalize_seq.sv
// Self-checking bench for normalize_seq: directed vector table, hand-written
// back-pressure and reset sequences, then random operands against a model.
module tb_normalize_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic        operator_in;
    logic [7:0]  exp_in;
    logic [28:0] mantis_in;
    logic [1:0]  loss_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic        operator;
    logic [7:0]  exp;
    logic [27:0] mantis;
    logic [1:0]  loss;

    int checks   = 0;
    int failures = 0;

    normalize_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sign_in     (sign_in),
        .operator_in (operator_in),
        .exp_in      (exp_in),
        .mantis_in   (mantis_in),
        .loss_in     (loss_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign        (sign),
        .operator    (operator),
        .exp         (exp),
        .mantis      (mantis),
        .loss        (loss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ei;
        logic [28:0] mi;
        logic [1:0]  li;
        logic        si;
        logic        oi;
        logic [7:0]  eo;
        logic [27:0] mo;
        logic [1:0]  lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0]  e;
        logic [27:0] m;
        logic [1:0]  l;
        int          lat;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: position of the leading one decides the shift count directly.
    function automatic res_t model(input logic [7:0] ei, input logic [28:0] mi, input logic [1:0] li);
        res_t        r;
        logic [28:0] t;
        int          p;
        int          k;
        int          s;
        r.l   = li;
        r.lat = 2;
        r.e   = ei;
        r.m   = mi[27:0];
        if (ei == 8'hFF) begin
            r.e = ei;
        end else if (mi == 29'd0) begin
            r.e = 8'd0;
            r.m = 28'd0;
        end else if (mi[28]) begin
            t   = mi >> 1;
            r.e = ei + 8'd1;
            r.m = (ei == 8'hFE) ? 28'd0 : t[27:0];
            r.l = li | {mi[0], mi[0]};
        end else begin
            p = 0;
            for (int i = 0; i < 28; i++) if (mi[i]) p = i;
            k = 27 - p;
            if (k == 0) begin
                r.e = ei;
            end else if (k < int'(ei)) begin
                t     = mi << k;
                r.e   = ei - 8'(k);
                r.m   = t[27:0];
                r.lat = 2 + k;
            end else begin
                s     = (ei == 8'd0) ? 1 : int'(ei);
                t     = mi << s;
                r.e   = 8'd0;
                r.m   = t[27:0];
                r.lat = (ei == 8'd0) ? 2 : int'(ei) + 1;
            end
        end
        return r;
    endfunction

    // Issue one op from IDLE with out_ready high; latency counts from the accept cycle.
    task automatic do_op(input logic [7:0] ei, input logic [28:0] mi, input logic [1:0] li,
                         input logic si, input logic oi,
                         output logic [7:0] eo, output logic [27:0] mo, output logic [1:0] lo,
                         output logic so, output logic oo, output int lat);
        exp_in      = ei;
        mantis_in   = mi;
        loss_in     = li;
        sign_in     = si;
        operator_in = oi;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        eo = exp;
        mo = mantis;
        lo = loss;
        so = sign;
        oo = operator;
        @(negedge clk);
    endtask

    vec_t        vecs[8];
    logic [7:0]  eo;
    logic [27:0] mo;
    logic [1:0]  lo;
    logic        so;
    logic        oo;
    int          lat;
    res_t        r;

    initial begin
        vecs[0] = '{8'h80, 29'h0800_0000, 2'b10, 1'b1, 1'b0, 8'h80, 28'h800_0000, 2'b10, 2};
        vecs[1] = '{8'h80, 29'h1000_0011, 2'b00, 1'b0, 1'b1, 8'h81, 28'h800_0008, 2'b11, 2};
        vecs[2] = '{8'h85, 29'h0000_0100, 2'b01, 1'b1, 1'b1, 8'h72, 28'h800_0000, 2'b01, 21};
        vecs[3] = '{8'h03, 29'h0010_0000, 2'b00, 1'b0, 1'b0, 8'h00, 28'h080_0000, 2'b00, 4};
        vecs[4] = '{8'hFE, 29'h1000_0000, 2'b00, 1'b0, 1'b0, 8'hFF, 28'h000_0000, 2'b00, 2};
        vecs[5] = '{8'h40, 29'h0000_0000, 2'b10, 1'b1, 1'b0, 8'h00, 28'h000_0000, 2'b10, 2};
        vecs[6] = '{8'h00, 29'h0000_0001, 2'b11, 1'b0, 1'b1, 8'h00, 28'h000_0002, 2'b11, 2};
        vecs[7] = '{8'hFF, 29'h0123_4567, 2'b01, 1'b1, 1'b0, 8'hFF, 28'h123_4567, 2'b01, 2};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        sign_in     = 1'b0;
        operator_in = 1'b0;
        exp_in      = 8'd0;
        mantis_in   = 29'd0;
        loss_in     = 2'd0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset exp", 32'(exp), 32'd0);
        check("reset mantis", 32'(mantis), 32'd0);
        check("reset loss/sign/op", 32'({loss, sign, operator}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].ei, vecs[i].mi, vecs[i].li, vecs[i].si, vecs[i].oi, eo, mo, lo, so, oo, lat);
            check($sformatf("vec%0d exp", i), 32'(eo), 32'(vecs[i].eo));
            check($sformatf("vec%0d mantis", i), 32'(mo), 32'(vecs[i].mo));
            check($sformatf("vec%0d loss", i), 32'(lo), 32'(vecs[i].lo));
            check($sformatf("vec%0d sign/op", i), 32'({so, oo}), 32'({vecs[i].si, vecs[i].oi}));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Back-pressure: hold a carry result while a second op waits upstream.
        exp_in    = 8'h80;
        mantis_in = 29'h1000_0011;
        loss_in   = 2'b00;
        sign_in   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_in    = 8'h10;
        mantis_in = 29'h0800_0000;
        loss_in   = 2'b01;
        sign_in   = 1'b0;
        lat       = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d valid/ready", c), 32'({out_valid, in_ready}), 32'b10);
            check($sformatf("bp hold%0d exp", c), 32'(exp), 32'h81);
            check($sformatf("bp hold%0d mantis", c), 32'(mantis), 32'h800_0008);
            check($sformatf("bp hold%0d loss/sign", c), 32'({loss, sign}), 32'b111);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release valid/ready", 32'({out_valid, in_ready}), 32'b01);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second accepted", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp second valid", 32'(out_valid), 32'd1);
        check("bp second exp", 32'(exp), 32'h10);
        check("bp second loss", 32'(loss), 32'b01);
        @(negedge clk);

        // Reset during a long cancellation abandons the op.
        exp_in    = 8'h85;
        mantis_in = 29'h0000_0100;
        loss_in   = 2'b11;
        sign_in   = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst mid-op valid/ready", 32'({out_valid, in_ready}), 32'b01);
        check("rst mid-op exp", 32'(exp), 32'd0);
        check("rst mid-op mantis", 32'(mantis), 32'd0);
        check("rst mid-op loss/sign/op", 32'({loss, sign, operator}), 32'd0);
        do_op(8'h85, 29'h0000_0100, 2'b00, 1'b0, 1'b0, eo, mo, lo, so, oo, lat);
        check("post-rst exp", 32'(eo), 32'h72);
        check("post-rst mantis", 32'(mo), 32'h800_0000);
        check("post-rst latency", 32'(lat), 32'd21);

        // Random operands, biased toward the exponent and mantissa corners.
        for (int n = 0; n < 300; n++) begin
            logic [7:0]  ei;
            logic [28:0] mi;
            logic [31:0] rnd;
            logic [1:0]  li;
            logic        si;
            logic        oi;
            int          pos;
            case ($urandom_range(0, 7))
                0:       ei = 8'h00;
                1:       ei = 8'h01;
                2:       ei = 8'hFF;
                3:       ei = 8'hFE;
                4:       ei = 8'($urandom_range(2, 30));
                default: ei = 8'($urandom);
            endcase
            pos = $urandom_range(0, 29);
            rnd = $urandom;
            if (pos == 29) mi = 29'd0;
            else mi = (rnd[28:0] & ((29'd1 << (pos + 1)) - 29'd1)) | (29'd1 << pos);
            li = 2'($urandom);
            si = 1'($urandom);
            oi = 1'($urandom);
            r  = model(ei, mi, li);
            do_op(ei, mi, li, si, oi, eo, mo, lo, so, oo, lat);
            check($sformatf("rnd%0d exp e=%0h m=%0h", n, ei, mi), 32'(eo), 32'(r.e));
            check($sformatf("rnd%0d mantis e=%0h m=%0h", n, ei, mi), 32'(mo), 32'(r.m));
            check($sformatf("rnd%0d loss", n), 32'(lo), 32'(r.l));
            check($sformatf("rnd%0d sign/op", n), 32'({so, oo}), 32'({si, oi}));
            check($sformatf("rnd%0d latency e=%0h m=%0h", n, ei, mi), 32'(lat), 32'(r.lat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
